// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Row/column matrix keypad scanner. It synchronises the row
//                inputs and steps a scan FSM on a divided tick. Presses and
//                releases are debounced, held keys auto-repeat, and key codes
//                are buffered in a small FIFO with a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int TICK_DIV   = 1048576,
  parameter int DEBOUNCE   = 2,
  parameter int REP_DELAY  = 24,
  parameter int REP_RATE   = 6,
  parameter int FIFO_DEPTH = 4,
  localparam int KW        = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  input  logic            repeat_en,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            overflow,
  input  logic            clr_ovf
);

  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LCW   = $clog2(ROWS + 1);
  localparam int DW    = $clog2(DEBOUNCE + 1);
  localparam int RPMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int PW    = $clog2(RPMAX + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_PRESSED  = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Row synchroniser and scan tick
  // --------------------------------------------------------------------------
  logic [ROWS-1:0] rs_meta;
  logic [ROWS-1:0] rs;
  logic [TW-1:0]   tick_cnt;
  logic            tick;

  // Two-flop synchroniser; idles at all ones (no key closed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_meta <= '1;
      rs      <= '1;
    end else begin
      rs_meta <= row;
      rs      <= rs_meta;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Free-running divider producing a one-clock tick every TICK_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Row pattern classification
  // --------------------------------------------------------------------------
  logic [RW-1:0]  low_pos;
  logic [LCW-1:0] low_cnt;
  logic           all_high;
  logic           one_low;

  // Count closed rows and remember where the (last) closed row sits.
  always_comb begin
    low_pos = '0;
    low_cnt = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!rs[i]) begin
        low_pos = RW'(i);
        low_cnt = low_cnt + LCW'(1);
      end
    end
  end

  assign all_high = (rs == '1);
  assign one_low  = (low_cnt == LCW'(1));

  // --------------------------------------------------------------------------
  // Scan FSM
  // --------------------------------------------------------------------------
  state_t          state, state_n;
  logic [CW-1:0]   idx, idx_n;
  logic [RW-1:0]   row_idx, row_idx_n;
  logic [ROWS-1:0] pattern, pattern_n;
  logic [DW-1:0]   deb_cnt, deb_n;
  logic [PW-1:0]   rep_cnt, rep_n;
  logic            rep_done, rep_done_n;
  logic            push;
  logic [KW-1:0]   push_code;

  // FSM state and its tick-driven counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      row_idx  <= '0;
      pattern  <= '1;
      deb_cnt  <= '0;
      rep_cnt  <= '0;
      rep_done <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      row_idx  <= row_idx_n;
      pattern  <= pattern_n;
      deb_cnt  <= deb_n;
      rep_cnt  <= rep_n;
      rep_done <= rep_done_n;
    end
  end

  // Code of the latched key; the column index is still held in idx.
  assign push_code = KW'(row_idx) * KW'(COLS) + KW'(idx);

  // Next-state logic, column drive and FIFO push requests.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    row_idx_n  = row_idx;
    pattern_n  = pattern;
    deb_n      = deb_cnt;
    rep_n      = rep_cnt;
    rep_done_n = rep_done;
    push       = 1'b0;
    col        = '0;
    case (state)
      ST_IDLE: begin
        if (tick && !all_high) begin
          state_n = ST_SCAN;
          idx_n   = '0;
        end
      end
      ST_SCAN: begin
        col = ~(COLS'(1) << idx);
        if (tick) begin
          if (all_high) begin
            if (idx == CW'(COLS - 1)) begin
              state_n = ST_IDLE;
            end else begin
              idx_n = idx + CW'(1);
            end
          end else if (one_low) begin
            pattern_n = rs;
            row_idx_n = low_pos;
            deb_n     = '0;
            state_n   = ST_DEBOUNCE;
          end else begin
            // Ambiguous multi-key closure: wait for a full release.
            deb_n   = '0;
            state_n = ST_RELEASE;
          end
        end
      end
      ST_DEBOUNCE: begin
        col = ~(COLS'(1) << idx);
        if (tick) begin
          if (rs == pattern) begin
            if (deb_cnt == DW'(DEBOUNCE - 1)) begin
              state_n    = ST_PRESSED;
              push       = 1'b1;
              deb_n      = '0;
              rep_n      = '0;
              rep_done_n = 1'b0;
            end else begin
              deb_n = deb_cnt + DW'(1);
            end
          end else begin
            deb_n   = '0;
            state_n = ST_IDLE;
          end
        end
      end
      ST_PRESSED: begin
        col = ~(COLS'(1) << idx);
        if (tick) begin
          if (all_high) begin
            state_n    = ST_RELEASE;
            deb_n      = '0;
            rep_n      = '0;
            rep_done_n = 1'b0;
          end else if (!repeat_en) begin
            rep_n      = '0;
            rep_done_n = 1'b0;
          end else if (rep_cnt == (rep_done ? PW'(REP_RATE - 1) : PW'(REP_DELAY - 1))) begin
            push       = 1'b1;
            rep_n      = '0;
            rep_done_n = 1'b1;
          end else begin
            rep_n = rep_cnt + PW'(1);
          end
        end
      end
      ST_RELEASE: begin
        if (tick) begin
          if (all_high) begin
            if (deb_cnt == DW'(DEBOUNCE - 1)) begin
              deb_n   = '0;
              state_n = ST_IDLE;
            end else begin
              deb_n = deb_cnt + DW'(1);
            end
          end else begin
            deb_n = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign key_held = (state == ST_PRESSED);

  // --------------------------------------------------------------------------
  // Key event FIFO
  // --------------------------------------------------------------------------
  logic [KW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          do_wr;
  logic          drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = key_valid && key_ready;
  // A pop in the same clock frees the slot the push needs.
  assign do_wr = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign key_valid = !empty;
  assign key_code  = mem[rd_ptr[AW-1:0]];

  // Storage and pointers; contents are cleared so reset discards old codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= push_code;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Sticky overflow; a drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner with a keypad matrix
//                model, directed vector table and randomized presses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int NR   = 4;
  localparam int NC   = 4;
  localparam int TDIV = 4;
  localparam int DEB  = 2;
  localparam int RD   = 24;
  localparam int RR   = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] row;
  logic [NC-1:0] col;
  logic          repeat_en = 1'b0;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          key_ready = 1'b0;
  logic          key_held;
  logic          overflow;
  logic          clr_ovf = 1'b0;

  logic [NR*NC-1:0] keys = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int got[$];
  int expq[$];

  keypad_scanner #(
    .ROWS(NR), .COLS(NC), .TICK_DIV(TDIV), .DEBOUNCE(DEB),
    .REP_DELAY(RD), .REP_RATE(RR), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .repeat_en(repeat_en),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its row low when its column is driven.
  always_comb begin
    row = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (keys[r*NC+c] && !col[c]) row[r] = 1'b0;
  end

  // Record every code the consumer takes from the FIFO.
  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) got.push_back(int'(key_code));
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
  endtask

  // Advance n scan ticks; returns 1 time unit after the tick edge.
  task automatic ticks(input int n);
    repeat (n) begin
      do step(); while (cyc % TDIV != 0);
    end
    #1;
  endtask

  // Reference: number of codes a press produces, from the repeat rules.
  function automatic int exp_count(input int h, input bit rep, input int off);
    int n = 1;
    if (rep)
      for (int t = 1; t < h; t++)
        if ((off == 0 || t < off) && (t == RD || (t > RD && (t - RD) % RR == 0))) n++;
    return n;
  endfunction

  // Press key (r,c) from an idle keypad; it stays closed for h ticks counted
  // from the tick it is accepted, then is released and the FSM settles.
  task automatic do_press(input int r, input int c, input int h, input bit rep,
                          input int off, output bit held_b4, output bit valid_b4,
                          output int code_b4, output bit held_after);
    repeat_en = rep;
    keys = '0;
    keys[r*NC+c] = 1'b1;
    ticks(2 + c + DEB);
    for (int t = 1; t < h; t++) begin
      if (off != 0 && t == off) repeat_en = 1'b0;
      ticks(1);
    end
    held_b4  = key_held;
    valid_b4 = key_valid;
    code_b4  = int'(key_code);
    keys = '0;
    ticks(1);
    held_after = key_held;
    ticks(DEB + 3);
    repeat_en = 1'b0;
  endtask

  task automatic drain_check(input string name);
    key_ready = 1'b1;
    repeat (8) step();
    #1;
    key_ready = 1'b0;
    ticks(1);
    chk({name, " count"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk({name, " code"}, got[i], expq[i]);
    got.delete();
    expq.delete();
  endtask

  typedef struct {
    int r; int c; int h; bit rep; int off; int exp_n;
  } vec_t;

  initial begin
    vec_t tbl[7];
    bit hb, vb, ha;
    int cb, code, n;

    tbl[0] = '{2, 1, 5,  1'b0, 0,  1};
    tbl[1] = '{0, 0, 1,  1'b0, 0,  1};
    tbl[2] = '{3, 3, 36, 1'b1, 0,  3};
    tbl[3] = '{3, 3, 36, 1'b0, 0,  1};
    tbl[4] = '{3, 3, 46, 1'b1, 30, 2};
    tbl[5] = '{1, 2, 25, 1'b1, 0,  2};
    tbl[6] = '{0, 3, 24, 1'b1, 0,  1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset col", int'(col), 0);
    chk("reset key_valid", int'(key_valid), 0);
    chk("reset key_code", int'(key_code), 0);
    chk("reset key_held", int'(key_held), 0);
    chk("reset overflow", int'(overflow), 0);
    rst_n = 1'b1;
    cyc = 0;
    ticks(2);

    // Directed vector table, consumer stalled during each press
    foreach (tbl[i]) begin
      code = tbl[i].r * NC + tbl[i].c;
      do_press(tbl[i].r, tbl[i].c, tbl[i].h, tbl[i].rep, tbl[i].off, hb, vb, cb, ha);
      chk("vec held while pressed", int'(hb), 1);
      chk("vec valid while pressed", int'(vb), 1);
      chk("vec head code", cb, code);
      chk("vec held after release", int'(ha), 0);
      chk("vec overflow", int'(overflow), 0);
      for (int k = 0; k < tbl[i].exp_n; k++) expq.push_back(code);
      drain_check("vec");
    end

    // Bounce: key opens during the first debounce tick
    keys = '0; keys[0] = 1'b1;
    ticks(2);
    keys = '0;
    ticks(5);
    chk("bounce1 key_valid", int'(key_valid), 0);
    // Bounce: only one matching debounce tick
    keys[0] = 1'b1;
    ticks(3);
    keys = '0;
    ticks(5);
    chk("bounce2 key_valid", int'(key_valid), 0);
    chk("bounce2 key_held", int'(key_held), 0);

    // Multi-key on one column: no event, column drive parked until release
    keys = '0;
    keys[0*NC+2] = 1'b1;
    keys[1*NC+2] = 1'b1;
    ticks(4);
    for (int k = 0; k < 5; k++) begin
      ticks(1);
      chk("multi col", int'(col), 0);
      chk("multi key_held", int'(key_held), 0);
    end
    keys = '0;
    ticks(DEB + 4);
    chk("multi key_valid", int'(key_valid), 0);
    do_press(3, 0, 1, 1'b0, 0, hb, vb, cb, ha);
    chk("after multi head code", cb, 12);
    expq.push_back(12);
    drain_check("after multi");

    // Overflow: five presses into a four-entry FIFO
    do_press(0, 0, 1, 1'b0, 0, hb, vb, cb, ha);
    do_press(1, 1, 1, 1'b0, 0, hb, vb, cb, ha);
    do_press(2, 2, 1, 1'b0, 0, hb, vb, cb, ha);
    do_press(3, 3, 1, 1'b0, 0, hb, vb, cb, ha);
    chk("full no overflow", int'(overflow), 0);
    chk("full key_code head", int'(key_code), 0);
    do_press(0, 3, 1, 1'b0, 0, hb, vb, cb, ha);
    chk("overflow set", int'(overflow), 1);
    clr_ovf = 1'b1;
    ticks(1);
    clr_ovf = 1'b0;
    chk("overflow cleared", int'(overflow), 0);
    // Push while full with a pop on the same clock must be kept
    keys = '0; keys[1*NC+0] = 1'b1;
    ticks(2 + 0 + DEB - 1);
    repeat (3) step();
    #1;
    key_ready = 1'b1;
    step();
    #1;
    key_ready = 1'b0;
    keys = '0;
    ticks(DEB + 4);
    chk("pop+push overflow", int'(overflow), 0);
    chk("pop+push head", int'(key_code), 5);
    expq = '{0, 5, 10, 15, 4};
    drain_check("overflow order");

    // Reset while pressed with two entries buffered
    do_press(0, 1, 1, 1'b0, 0, hb, vb, cb, ha);
    keys = '0; keys[1*NC+1] = 1'b1;
    ticks(2 + 1 + DEB);
    chk("pre-reset key_held", int'(key_held), 1);
    chk("pre-reset key_valid", int'(key_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset key_valid", int'(key_valid), 0);
    chk("mid reset col", int'(col), 0);
    chk("mid reset key_held", int'(key_held), 0);
    chk("mid reset key_code", int'(key_code), 0);
    keys = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    ticks(2);
    chk("post reset key_valid", int'(key_valid), 0);
    got.delete();
    expq.delete();
    do_press(2, 3, 1, 1'b0, 0, hb, vb, cb, ha);
    chk("post reset head code", cb, 11);
    expq.push_back(11);
    drain_check("post reset");

    // Randomized presses against the reference repeat model
    key_ready = 1'b1;
    for (int it = 0; it < 25; it++) begin
      int r = $urandom_range(0, NR - 1);
      int c = $urandom_range(0, NC - 1);
      int h = $urandom_range(1, 45);
      bit rep = 1'($urandom_range(0, 1));
      do_press(r, c, h, rep, 0, hb, vb, cb, ha);
      chk("rand held while pressed", int'(hb), 1);
      n = exp_count(h, rep, 0);
      for (int k = 0; k < n; k++) expq.push_back(r * NC + c);
      drain_check("rand");
      key_ready = 1'b1;
    end
    key_ready = 1'b0;
    chk("final overflow", int'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL provide parameter ROWS, default 4, number of keypad row inputs.
REQ-002 The block SHALL provide parameter COLS, default 4, number of keypad column drives.
REQ-003 The block SHALL provide parameter TICK_DIV, default 1048576, clk cycles per scan tick.
REQ-004 The block SHALL provide parameter DEBOUNCE, default 2, consecutive stable ticks required to accept a press or a release.
REQ-005 The block SHALL provide parameter REP_DELAY, default 24, ticks from accepted press to first repeat.
REQ-006 The block SHALL provide parameter REP_RATE, default 6, ticks between subsequent repeats.
REQ-007 The block SHALL provide parameter FIFO_DEPTH, default 4, key-event buffer entries (power of two, at least 2).
REQ-008 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-009 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-010 The block SHALL have port row, input, ROWS bits, keypad rows, active-low (0 = key closed on the driven column).
REQ-011 The block SHALL have port col, output, COLS bits, column drive, active-low.
REQ-012 The block SHALL have port repeat_en, input, 1 bit, enables auto-repeat while a key is held.
REQ-013 The block SHALL have port key_code, output, KW = clog2(ROWS*COLS) bits, key code at the FIFO head.
REQ-014 The block SHALL have port key_valid, output, 1 bit, FIFO non-empty.
REQ-015 The block SHALL have port key_ready, input, 1 bit, consumer accepts the head entry.
REQ-016 The block SHALL have port key_held, output, 1 bit, high while the FSM is in PRESSED.
REQ-017 The block SHALL have port overflow, output, 1 bit, sticky flag set when an event is dropped.
REQ-018 The block SHALL have port clr_ovf, input, 1 bit, synchronous clear of overflow.

Function
REQ-019 The block SHALL pass row through a 2-flop synchroniser; all decisions SHALL use the synchronised value rs.
REQ-020 The block SHALL generate a one-clk tick every TICK_DIV clocks using a free-running counter; FSM state, debounce and repeat counters SHALL change only on tick.
REQ-021 The FSM SHALL have states IDLE, SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-022 In IDLE, col SHALL be all zeros; when rs != all-ones on a tick, the FSM SHALL go to SCAN with column index 0.
REQ-023 In SCAN, col SHALL drive only bit idx low; when rs has exactly one bit low, the FSM SHALL latch row_idx and col_idx and go to DEBOUNCE.
REQ-024 In SCAN, when rs is all ones, idx SHALL increment; after idx = COLS-1, the FSM SHALL return to IDLE.
REQ-025 In SCAN, when two or more bits of rs are low (multi-key), the FSM SHALL go to RELEASE without producing an event.
REQ-026 In DEBOUNCE, the debounce count SHALL increment when rs equals the latched pattern, and the FSM SHALL enter PRESSED when the count reaches DEBOUNCE.
REQ-027 In DEBOUNCE, any mismatch of rs against the latched pattern SHALL send the FSM to IDLE without an event.
REQ-028 On entry to PRESSED, the block SHALL push key code row_idx*COLS+col_idx into the FIFO exactly once.
REQ-029 In PRESSED with repeat_en=1, the block SHALL push the same code after REP_DELAY ticks and then every REP_RATE ticks.
REQ-030 Deasserting repeat_en SHALL reset the repeat counter and stop further repeat pushes.
REQ-031 In PRESSED, the first tick with rs all ones SHALL move the FSM to RELEASE.
REQ-032 In RELEASE, col SHALL be all zeros, and the FSM SHALL return to IDLE after DEBOUNCE consecutive all-ones ticks; any low bit SHALL restart the count.
REQ-033 The FIFO SHALL pop when key_valid && key_ready.
REQ-034 key_code SHALL always present the head entry.
REQ-035 A push while the FIFO is full SHALL be dropped and SHALL set overflow, except when a pop occurs in the same clk, in which case the push SHALL succeed.
REQ-036 clr_ovf SHALL clear overflow; if a drop and clr_ovf occur in the same clk, overflow SHALL be set.

Reset
REQ-037 While rst_n=0, the block SHALL set FSM=IDLE, col=all zeros, tick counter=0, debounce and repeat counters=0, FIFO empty, key_valid=0, key_code=0, key_held=0, overflow=0, and synchroniser flops=all ones.
REQ-038 Assertion of rst_n mid-scan or mid-press SHALL discard all in-flight and buffered events.

Verification
REQ-039 Bench SHALL cover: defaults, TICK_DIV=4; hold key row2/col1 -> exactly one entry code 9, key_valid high, key_held high until release.
REQ-040 Bench SHALL cover: bounce of 1 tick on row0/col0 -> no entry; stable for 2 ticks -> code 0.
REQ-041 Bench SHALL cover: repeat_en=1, hold code 15 for 24+2*6 ticks -> 3 entries of code 15; with repeat_en=0 -> 1 entry.
REQ-042 Bench SHALL cover: two rows low on one column -> no entry, FSM returns to IDLE only after release.
REQ-043 Bench SHALL cover: key_ready=0 with 5 distinct presses -> 4 entries in order, overflow=1; clr_ovf -> overflow=0.
REQ-044 Bench SHALL cover: rst_n pulse while in PRESSED with 2 entries buffered -> key_valid=0, col=0000, press after release accepted normally.
